tile_prefetcher: RTL and testbench

TILE_PREFETCHER -- requirements
Module: tile_prefetcher

---
 rtl/prefetch_pkg.sv | 30 +++
 rtl/prefetch_addr_gen.sv | 82 ++++++++
 rtl/tile_prefetcher.sv | 224 ++++++++++++++++++++++
 tb/tb_tile_prefetcher.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prefetch_pkg                                                     |
// | Shared FSM state type and default parameters of tile_prefetcher. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package prefetch_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_N_REF      = 2;
    localparam int DEF_GROUP_ROWS = 4;
    localparam int DEF_TILE_SIZE  = 16;
    localparam int DEF_HALO       = 1;
    localparam int DEF_BPP        = 2;
    localparam int DEF_MAX_OUT    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // A single reference frame still needs a one-bit index.
    function automatic int ref_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prefetch_addr_gen                                                |
// | Clamped fetch window (registered in CALC) and per-row address.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module prefetch_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int GROUP_ROWS = 4,
    parameter int TILE_SIZE  = 16,
    parameter int HALO       = 1,
    parameter int BPP        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  calc,
    input  logic [15:0]           group_x,
    input  logic [15:0]           group_y,
    input  logic [15:0]           frame_width,
    input  logic [15:0]           frame_height,
    input  logic [15:0]           row,
    input  logic [ADDR_WIDTH-1:0] base,
    output logic                  empty,
    output logic [15:0]           y0,
    output logic [15:0]           y1,
    output logic [15:0]           len,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic signed [17:0] c_halo = 18'(HALO);
    localparam logic signed [17:0] c_rows = 18'(GROUP_ROWS - 1 + HALO);
    localparam logic signed [17:0] c_cols = 18'(TILE_SIZE - 1 + HALO);
    localparam logic signed [17:0] c_bpp  = 18'(BPP);
    localparam logic signed [17:0] c_zero = '0;

    logic signed [17:0] w_gx, w_gy, w_fw_m1, w_fh_m1;
    logic signed [17:0] w_x0_raw, w_x1_raw, w_y0_raw, w_y1_raw;
    logic signed [17:0] w_x0, w_x1, w_y0, w_y1, w_len;
    logic [15:0]        r_x0, r_y0, r_y1, r_len;
    logic               w_unused;

    always_comb begin
        w_gx     = signed'({2'b00, group_x});
        w_gy     = signed'({2'b00, group_y});
        w_fw_m1  = signed'({2'b00, frame_width}) - 18'sd1;
        w_fh_m1  = signed'({2'b00, frame_height}) - 18'sd1;
        w_y0_raw = w_gy - c_halo;
        w_y1_raw = w_gy + c_rows;
        w_x0_raw = w_gx - c_halo;
        w_x1_raw = w_gx + c_cols;
        w_y0     = (w_y0_raw < c_zero) ? c_zero : w_y0_raw;
        w_y1     = (w_y1_raw > w_fh_m1) ? w_fh_m1 : w_y1_raw;
        w_x0     = (w_x0_raw < c_zero) ? c_zero : w_x0_raw;
        w_x1     = (w_x1_raw > w_fw_m1) ? w_fw_m1 : w_x1_raw;
        w_len    = (w_x1 - w_x0 + 18'sd1) * c_bpp;
        empty    = (w_y0 > w_y1) || (w_x0 > w_x1);
    end

    // Upper bits only matter for the empty test; a non-empty window fits 16 bits.
    assign w_unused = ^{w_y0[17:16], w_y1[17:16], w_x0[17:16], w_len[17:16]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0  <= '0;
            r_y0  <= '0;
            r_y1  <= '0;
            r_len <= '0;
        end else if (calc) begin
            r_x0  <= w_x0[15:0];
            r_y0  <= w_y0[15:0];
            r_y1  <= w_y1[15:0];
            r_len <= w_len[15:0];
        end
    end

    assign y0   = r_y0;
    assign y1   = r_y1;
    assign len  = r_len;
    assign addr = base + ADDR_WIDTH'((40'(row) * 40'(frame_width) + 40'(r_x0)) * 40'(BPP));

endmodule
`default_nettype wire

// File: rtl/tile_prefetcher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tile_prefetcher                                                  |
// | Issues one DRAM row request per enabled reference frame and row. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tile_prefetcher
    import prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int N_REF      = DEF_N_REF,
    parameter int GROUP_ROWS = DEF_GROUP_ROWS,
    parameter int TILE_SIZE  = DEF_TILE_SIZE,
    parameter int HALO       = DEF_HALO,
    parameter int BPP        = DEF_BPP,
    parameter int MAX_OUT    = DEF_MAX_OUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 frame_width,
    input  logic [15:0]                 frame_height,
    input  logic [N_REF*ADDR_WIDTH-1:0] ref_base,
    input  logic [N_REF-1:0]            ref_enable,
    input  logic                        group_done,
    input  logic [15:0]                 group_x,
    input  logic [15:0]                 group_y,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [ADDR_WIDTH-1:0]       req_addr,
    output logic [15:0]                 req_len,
    output logic [ref_w(N_REF)-1:0]     req_ref,
    input  logic                        dram_done,
    output logic                        group_fetched,
    output logic                        busy,
    output logic                        overflow,
    output logic                        protocol_err
);

    localparam int REF_W = ref_w(N_REF);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0] c_max_out = OUT_W'(MAX_OUT);

    state_t r_state, w_state_nxt;

    logic [15:0]                 r_gx, r_gy, r_fw, r_fh;
    logic [N_REF*ADDR_WIDTH-1:0] r_base;
    logic [N_REF-1:0]            r_en;
    logic                        r_p_v;
    logic [15:0]                 r_p_gx, r_p_gy, r_p_fw, r_p_fh;
    logic [N_REF*ADDR_WIDTH-1:0] r_p_base;
    logic [N_REF-1:0]            r_p_en;
    logic [REF_W-1:0]            r_ref;
    logic [15:0]                 r_off;
    logic [OUT_W-1:0]            r_out;
    logic                        r_overflow, r_protocol_err;

    logic                  w_empty, w_first_ok, w_next_ok;
    logic [REF_W-1:0]      w_first_ref, w_next_ref;
    logic [15:0]           w_y0, w_y1, w_len, w_row;
    logic [ADDR_WIDTH-1:0] w_base, w_addr;
    logic                  w_acc, w_row_last, w_last_req, w_drain_done;
    logic                  w_pend_take, w_direct, w_fill, w_drop;

    prefetch_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .GROUP_ROWS (GROUP_ROWS),
        .TILE_SIZE  (TILE_SIZE),
        .HALO       (HALO),
        .BPP        (BPP)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .calc         (r_state == CALC),
        .group_x      (r_gx),
        .group_y      (r_gy),
        .frame_width  (r_fw),
        .frame_height (r_fh),
        .row          (w_row),
        .base         (w_base),
        .empty        (w_empty),
        .y0           (w_y0),
        .y1           (w_y1),
        .len          (w_len),
        .addr         (w_addr)
    );

    assign w_row  = w_y0 + r_off;
    assign w_base = r_base[int'(r_ref)*ADDR_WIDTH +: ADDR_WIDTH];

    // Lowest enabled frame overall, and lowest enabled frame above the current one.
    always_comb begin
        w_first_ok  = 1'b0;
        w_first_ref = '0;
        w_next_ok   = 1'b0;
        w_next_ref  = '0;
        for (int i = N_REF - 1; i >= 0; i--) begin
            if (r_en[i]) begin
                w_first_ok  = 1'b1;
                w_first_ref = REF_W'(i);
            end
            if (r_en[i] && (i > int'(r_ref))) begin
                w_next_ok  = 1'b1;
                w_next_ref = REF_W'(i);
            end
        end
    end

    assign req_valid    = (r_state == ISSUE) && (r_out < c_max_out);
    assign w_acc        = req_valid && req_ready;
    assign w_row_last   = (w_row == w_y1);
    assign w_last_req   = w_row_last && !w_next_ok;
    assign w_drain_done = (r_state == DRAIN) && (r_out == '0);

    // The slot is released the same cycle it is consumed, so a new group_done can refill it.
    assign w_pend_take = r_p_v && ((r_state == IDLE) || w_drain_done);
    assign w_direct    = group_done && (r_state == IDLE) && !r_p_v;
    assign w_fill      = group_done && !w_direct && (!r_p_v || w_pend_take);
    assign w_drop      = group_done && r_p_v && !w_pend_take;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        busy          = (r_state != IDLE);
        group_fetched = 1'b0;
        case (r_state)
            IDLE:  if (w_direct || r_p_v) w_state_nxt = CALC;
            CALC:  w_state_nxt = (!w_first_ok || w_empty) ? DRAIN : ISSUE;
            ISSUE: if (w_acc && w_last_req) w_state_nxt = DRAIN;
            DRAIN: begin
                if (r_out == '0) begin
                    group_fetched = 1'b1;
                    w_state_nxt   = r_p_v ? CALC : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gx       <= '0;
            r_gy       <= '0;
            r_fw       <= '0;
            r_fh       <= '0;
            r_base     <= '0;
            r_en       <= '0;
            r_p_v      <= 1'b0;
            r_p_gx     <= '0;
            r_p_gy     <= '0;
            r_p_fw     <= '0;
            r_p_fh     <= '0;
            r_p_base   <= '0;
            r_p_en     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pend_take) begin
                r_gx   <= r_p_gx;
                r_gy   <= r_p_gy;
                r_fw   <= r_p_fw;
                r_fh   <= r_p_fh;
                r_base <= r_p_base;
                r_en   <= r_p_en;
            end else if (w_direct) begin
                r_gx   <= group_x;
                r_gy   <= group_y;
                r_fw   <= frame_width;
                r_fh   <= frame_height;
                r_base <= ref_base;
                r_en   <= ref_enable;
            end
            if (w_fill) begin
                r_p_v    <= 1'b1;
                r_p_gx   <= group_x;
                r_p_gy   <= group_y;
                r_p_fw   <= frame_width;
                r_p_fh   <= frame_height;
                r_p_base <= ref_base;
                r_p_en   <= ref_enable;
            end else if (w_pend_take) begin
                r_p_v <= 1'b0;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref          <= '0;
            r_off          <= '0;
            r_out          <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (r_state == CALC) begin
                r_ref <= w_first_ref;
                r_off <= '0;
            end else if (w_acc) begin
                if (!w_row_last) begin
                    r_off <= r_off + 16'd1;
                end else if (w_next_ok) begin
                    r_ref <= w_next_ref;
                    r_off <= '0;
                end
            end
            case ({w_acc, dram_done})
                2'b10:   r_out <= r_out + OUT_W'(1);
                2'b01:   if (r_out != '0) r_out <= r_out - OUT_W'(1);
                default: r_out <= r_out;
            endcase
            if (dram_done && (r_out == '0)) r_protocol_err <= 1'b1;
        end
    end

    assign req_addr     = w_addr;
    assign req_len      = w_len;
    assign req_ref      = r_ref;
    assign overflow     = r_overflow;
    assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_tile_prefetcher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tile_prefetcher                                               |
// | Table vectors plus request scoreboard for tile_prefetcher.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_tile_prefetcher;

    localparam int HALO = 1;
    localparam int ROWS = 4;
    localparam int TILE = 16;
    localparam int BPP  = 2;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        logic [0:0]  rref;
    } req_t;

    typedef struct {
        int          gx, gy, fw, fh;
        logic [31:0] b0, b1;
        logic [1:0]  en;
        int          n;
        logic [31:0] a0;
        int          len;
    } vec_t;

    logic        clk, rst;
    logic [15:0] frame_width, frame_height, group_x, group_y;
    logic [63:0] ref_base;
    logic [1:0]  ref_enable;
    logic        group_done, req_valid, req_ready, dram_done;
    logic [31:0] req_addr;
    logic [15:0] req_len;
    logic [0:0]  req_ref;
    logic        group_fetched, busy, overflow, protocol_err;

    tile_prefetcher dut (
        .clk           (clk),
        .rst           (rst),
        .frame_width   (frame_width),
        .frame_height  (frame_height),
        .ref_base      (ref_base),
        .ref_enable    (ref_enable),
        .group_done    (group_done),
        .group_x       (group_x),
        .group_y       (group_y),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_ref       (req_ref),
        .dram_done     (dram_done),
        .group_fetched (group_fetched),
        .busy          (busy),
        .overflow      (overflow),
        .protocol_err  (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    req_t        sb_q[$];
    vec_t        vecs[7];
    int          n_checks, n_errors;
    int          acc_cnt, done_cnt, grp_acc, fetched_cnt;
    bit          auto_mode, prev_stall;
    logic [31:0] stall_addr, first_addr;
    logic [15:0] stall_len, first_len;
    logic [0:0]  stall_ref;
    logic        s_valid, s_fetched;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", nm, got, want);
        end
    endtask

    // Independent model of the window clamp and request order.
    task automatic push_group(input int gx, input int gy, input int fw, input int fh,
                              input logic [31:0] b0, input logic [31:0] b1, input logic [1:0] en);
        int y0, y1, x0, x1;
        req_t e;
        logic [31:0] bs [2];
        bs[0] = b0;
        bs[1] = b1;
        y0 = (gy - HALO < 0) ? 0 : gy - HALO;
        x0 = (gx - HALO < 0) ? 0 : gx - HALO;
        y1 = gy + ROWS - 1 + HALO;
        x1 = gx + TILE - 1 + HALO;
        if (y1 > fh - 1) y1 = fh - 1;
        if (x1 > fw - 1) x1 = fw - 1;
        for (int r = 0; r < 2; r++) begin
            if (en[r] && x0 <= x1) begin
                for (int row = y0; row <= y1; row++) begin
                    e.addr = bs[r] + 32'((row * fw + x0) * BPP);
                    e.len  = 16'((x1 - x0 + 1) * BPP);
                    e.rref = 1'(r);
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic start_group(input int gx, input int gy, input int fw, input int fh,
                               input logic [31:0] b0, input logic [31:0] b1,
                               input logic [1:0] en, input bit expect_run);
        group_x      = 16'(gx);
        group_y      = 16'(gy);
        frame_width  = 16'(fw);
        frame_height = 16'(fh);
        ref_base     = {b1, b0};
        ref_enable   = en;
        group_done   = 1'b1;
        grp_acc      = 0;
        if (expect_run) push_group(gx, gy, fw, fh, b0, b1, en);
    endtask

    // One clock: sample/score at negedge, drive at posedge+1.
    task automatic tick();
        req_t e;
        @(negedge clk);
        s_valid   = req_valid;
        s_fetched = group_fetched;
        if (auto_mode && prev_stall) begin
            n_checks++;
            if (!(req_valid && req_addr == stall_addr && req_len == stall_len && req_ref == stall_ref)) begin
                n_errors++;
                $display("FAIL stall_hold: valid=%0b addr=%h len=%0d ref=%0d, required valid=1 addr=%h len=%0d ref=%0d",
                         req_valid, req_addr, req_len, req_ref, stall_addr, stall_len, stall_ref);
            end
        end
        prev_stall = req_valid && !req_ready;
        stall_addr = req_addr;
        stall_len  = req_len;
        stall_ref  = req_ref;
        if (req_valid && req_ready) begin
            acc_cnt++;
            grp_acc++;
            if (grp_acc == 1) begin
                first_addr = req_addr;
                first_len  = req_len;
            end
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_req: addr=%h len=%0d ref=%0d, required no request", req_addr, req_len, req_ref);
            end else begin
                e = sb_q.pop_front();
                if (req_addr !== e.addr || req_len !== e.len || req_ref !== e.rref) begin
                    n_errors++;
                    $display("FAIL req_fields: addr=%h len=%0d ref=%0d, required addr=%h len=%0d ref=%0d",
                             req_addr, req_len, req_ref, e.addr, e.len, e.rref);
                end
            end
        end
        if (group_fetched) fetched_cnt++;
        @(posedge clk);
        #1;
        group_done = 1'b0;
        dram_done  = 1'b0;
        if (auto_mode) begin
            req_ready = ($urandom_range(0, 3) != 0);
            if (acc_cnt > done_cnt && $urandom_range(0, 1) == 1) begin
                dram_done = 1'b1;
                done_cnt++;
            end
        end
    endtask

    task automatic wait_fetched(input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (fetched_cnt < target && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (fetched_cnt < target) begin
            n_errors++;
            $display("FAIL %s_timeout: group_fetched count %0d, required %0d within %0d cycles", nm, fetched_cnt, target, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required finish within 1000000 ns");
        $fatal(1);
    end

    initial begin
        int f0;
        logic [2:0] seq;
        vecs[0] = '{16, 8, 64, 32, 32'h1000, 32'h8000, 2'b01, 6, 32'h139E, 36};
        vecs[1] = '{0, 0, 64, 32, 32'h1000, 32'h8000, 2'b01, 5, 32'h1000, 34};
        vecs[2] = '{48, 28, 64, 32, 32'h1000, 32'h8000, 2'b11, 10, 32'h1DDE, 34};
        vecs[3] = '{16, 8, 64, 32, 32'h1000, 32'h8000, 2'b10, 6, 32'h839E, 36};
        vecs[4] = '{16, 8, 64, 32, 32'h1000, 32'h8000, 2'b00, 0, 32'h0, 0};
        vecs[5] = '{100, 0, 64, 32, 32'h1000, 32'h8000, 2'b11, 0, 32'h0, 0};
        vecs[6] = '{0, 0, 8, 2, 32'h1000, 32'h8000, 2'b01, 2, 32'h1000, 16};

        n_checks = 0; n_errors = 0; acc_cnt = 0; done_cnt = 0; grp_acc = 0; fetched_cnt = 0;
        auto_mode = 0; prev_stall = 0;
        rst = 1'b1; group_done = 1'b0; req_ready = 1'b0; dram_done = 1'b0;
        group_x = '0; group_y = '0; frame_width = '0; frame_height = '0; ref_base = '0; ref_enable = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_group_fetched", group_fetched, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_protocol_err", protocol_err, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_len", req_len, 0);
        chk("rst_req_ref", req_ref, 0);

        auto_mode = 1;
        for (int i = 0; i < 7; i++) begin
            start_group(vecs[i].gx, vecs[i].gy, vecs[i].fw, vecs[i].fh, vecs[i].b0, vecs[i].b1, vecs[i].en, 1);
            f0 = fetched_cnt;
            wait_fetched(f0 + 1, 500, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_count", i), 64'(grp_acc), 64'(vecs[i].n));
            chk($sformatf("vec%0d_sb_empty", i), 64'(sb_q.size()), 0);
            if (vecs[i].n > 0) begin
                chk($sformatf("vec%0d_first_addr", i), first_addr, vecs[i].a0);
                chk($sformatf("vec%0d_first_len", i), first_len, 64'(vecs[i].len));
            end
        end

        // Empty group: group_fetched two cycles after group_done.
        start_group(16, 8, 64, 32, 32'h1000, 32'h8000, 2'b00, 0);
        tick(); seq[2] = s_fetched;
        tick(); seq[1] = s_fetched;
        tick(); seq[0] = s_fetched;
        chk("empty_fetched_latency", seq, 3'b001);

        // First req_valid two cycles after group_done.
        start_group(16, 8, 64, 32, 32'h1000, 32'h8000, 2'b01, 1);
        f0 = fetched_cnt;
        tick(); seq[2] = s_valid;
        tick(); seq[1] = s_valid;
        tick(); seq[0] = s_valid;
        chk("first_valid_latency", seq, 3'b001);
        wait_fetched(f0 + 1, 500, "latency");

        // Outstanding limit.
        auto_mode = 0; req_ready = 1'b1;
        start_group(16, 8, 64, 32, 32'h1000, 32'h8000, 2'b01, 1);
        f0 = fetched_cnt;
        repeat (12) tick();
        chk("maxout_accepts", 64'(grp_acc), 4);
        chk("maxout_valid_low", s_valid, 0);
        dram_done = 1'b1; done_cnt++;
        repeat (5) tick();
        chk("maxout_refill", 64'(grp_acc), 5);
        auto_mode = 1;
        wait_fetched(f0 + 1, 500, "maxout");

        // Three group_done pulses: second queued, third dropped.
        f0 = fetched_cnt;
        start_group(16, 8, 64, 32, 32'h1000, 32'h8000, 2'b01, 1);
        tick();
        start_group(0, 0, 64, 32, 32'h1000, 32'h8000, 2'b01, 1);
        tick();
        start_group(32, 16, 64, 32, 32'h1000, 32'h8000, 2'b01, 0);
        tick();
        wait_fetched(f0 + 2, 1000, "overflow");
        repeat (20) tick();
        chk("overflow_fetched_pulses", 64'(fetched_cnt - f0), 2);
        chk("overflow_flag", overflow, 1);
        chk("overflow_sb_empty", 64'(sb_q.size()), 0);
        chk("overflow_idle", busy, 0);
        chk("no_protocol_err", protocol_err, 0);

        // Reset in ISSUE with two outstanding, then stray completions.
        auto_mode = 0; req_ready = 1'b1;
        start_group(16, 8, 64, 32, 32'h1000, 32'h8000, 2'b01, 1);
        repeat (4) tick();
        chk("rst_mid_accepts", 64'(grp_acc), 2);
        req_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        chk("rst_mid_req_valid", req_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_overflow", overflow, 0);
        chk("rst_mid_req_addr", req_addr, 0);
        chk("rst_mid_protocol_err", protocol_err, 0);
        dram_done = 1'b1;
        tick();
        dram_done = 1'b1;
        tick();
        tick();
        chk("stray_done_protocol_err", protocol_err, 1);
        chk("stray_done_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
